// File: rtl/rv32_multicycle_ctrl_if.sv
// Unified memory bus handshake between the RV32I multicycle controller (master)
// and the memory subsystem (slave).
interface rv32_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP.
// Optional performance counters are enabled by defining RV_CTRL_PERF_EN.
module rv32_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef RV_CTRL_PERF_EN
  , parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [31:0]            i_instr,
  input  logic                   i_zero,
  input  logic                   i_less,
  rv32_multicycle_ctrl_if.master io_mem,
  output logic                   o_ir_we,
  output logic                   o_pc_we,
  output logic                   o_reg_we,
  output logic [3:0]             o_alu_op,
  output logic [1:0]             o_alu_asrc,
  output logic                   o_alu_bsrc,
  output logic [2:0]             o_imm_sel,
  output logic [1:0]             o_wb_sel,
  output logic [2:0]             o_branch,
  output logic                   o_cmp_unsigned,
  output logic                   o_halted,
  output logic [1:0]             o_trap_cause
`ifdef RV_CTRL_PERF_EN
  , output logic [CNT_WIDTH-1:0] o_cycle_count,
  output logic [CNT_WIDTH-1:0]   o_instret_count
`endif
);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP} state_t;

  state_t      r_state;
  logic [15:0] r_timeout;
  logic        r_mem_req, r_mem_we, r_mem_addr_sel, r_pc_we, r_reg_we;
  logic [3:0]  r_alu_op;
  logic [1:0]  r_alu_asrc, r_wb_sel, r_trap_cause;
  logic        r_alu_bsrc, r_cmp_unsigned, r_halted;
  logic [2:0]  r_imm_sel, r_branch;

  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;
  logic        w_ready, w_timeout_hit, w_unused;
  logic        w_is_load, w_is_store, w_is_branch, w_is_fence, w_is_system, w_is_legal;
  logic [3:0]  w_alu_op;
  logic [1:0]  w_alu_asrc, w_wb_sel;
  logic        w_alu_bsrc, w_cmp_unsigned;
  logic [2:0]  w_imm_sel, w_branch;

  assign w_opcode      = i_instr[6:0];
  assign w_func3       = i_instr[14:12];
  assign w_is_load     = (w_opcode == OPC_LOAD);
  assign w_is_store    = (w_opcode == OPC_STORE);
  assign w_is_branch   = (w_opcode == OPC_BRANCH);
  assign w_is_fence    = (w_opcode == OPC_FENCE);
  assign w_is_system   = (w_opcode == OPC_SYSTEM);
  // mem_ready only means something while a request is outstanding.
  assign w_ready       = io_mem.mem_ready && r_mem_req;
  assign w_timeout_hit = (r_timeout == TIMEOUT_LAST);
  assign w_unused      = ^{i_zero, i_less, i_instr};

  always_comb begin
    w_alu_op       = 4'b0000;
    w_alu_asrc     = 2'd0;
    w_alu_bsrc     = 1'b0;
    w_imm_sel      = 3'd0;
    w_cmp_unsigned = 1'b0;
    w_branch       = 3'b000;
    w_wb_sel       = 2'd0;
    w_is_legal     = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        w_alu_op       = {i_instr[30], w_func3};
        w_cmp_unsigned = (w_func3 == 3'b011);
      end
      OPC_OPIMM: begin
        // The immediate's bit 30 is only an opcode modifier for SRAI.
        w_alu_op       = {i_instr[30] && (w_func3 == 3'b101), w_func3};
        w_alu_bsrc     = 1'b1;
        w_cmp_unsigned = (w_func3 == 3'b011);
      end
      OPC_LUI:   begin w_alu_asrc = 2'd2; w_alu_bsrc = 1'b1; w_imm_sel = 3'd2; end
      OPC_AUIPC: begin w_alu_asrc = 2'd1; w_alu_bsrc = 1'b1; w_imm_sel = 3'd2; end
      OPC_JAL: begin
        w_alu_asrc = 2'd1; w_alu_bsrc = 1'b1; w_imm_sel = 3'd4;
        w_branch   = 3'b001; w_wb_sel = 2'd2;
      end
      OPC_JALR: begin w_alu_bsrc = 1'b1; w_branch = 3'b010; w_wb_sel = 2'd2; end
      OPC_BRANCH: begin
        w_alu_op       = 4'b1000;
        w_imm_sel      = 3'd3;
        w_branch       = {1'b1, w_func3[2], w_func3[0]};
        w_cmp_unsigned = w_func3[1];
      end
      OPC_LOAD:   begin w_alu_bsrc = 1'b1; w_wb_sel = 2'd1; end
      OPC_STORE:  begin w_alu_bsrc = 1'b1; w_imm_sel = 3'd1; end
      OPC_FENCE, OPC_SYSTEM: ;
      default:    w_is_legal = 1'b0;
    endcase
  end

  // Each transition loads the registered outputs the destination state drives.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_FETCH;
      r_timeout      <= 16'd0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr_sel <= 1'b0;
      r_pc_we        <= 1'b0;
      r_reg_we       <= 1'b0;
      r_alu_op       <= 4'd0;
      r_alu_asrc     <= 2'd0;
      r_alu_bsrc     <= 1'b0;
      r_imm_sel      <= 3'd0;
      r_wb_sel       <= 2'd0;
      r_branch       <= 3'd0;
      r_cmp_unsigned <= 1'b0;
      r_halted       <= 1'b0;
      r_trap_cause   <= 2'd0;
    end else begin
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr_sel <= 1'b0;
      r_pc_we        <= 1'b0;
      r_reg_we       <= 1'b0;
      r_alu_op       <= 4'd0;
      r_alu_asrc     <= 2'd0;
      r_alu_bsrc     <= 1'b0;
      r_imm_sel      <= 3'd0;
      r_wb_sel       <= 2'd0;
      r_branch       <= 3'd0;
      r_cmp_unsigned <= 1'b0;
      if (r_state == S_EXECUTE || (r_state == S_MEM && !(w_ready && r_mem_we))) begin
        r_alu_op       <= w_alu_op;
        r_alu_asrc     <= w_alu_asrc;
        r_alu_bsrc     <= w_alu_bsrc;
        r_imm_sel      <= w_imm_sel;
        r_cmp_unsigned <= w_cmp_unsigned;
      end
      case (r_state)
        S_FETCH: begin
          if (w_ready) begin
            r_state <= S_DECODE;
          end else if (r_mem_req && w_timeout_hit) begin
            r_state <= S_TRAP; r_halted <= 1'b1; r_trap_cause <= 2'd2;
          end else begin
            r_mem_req <= 1'b1;
            if (r_mem_req) r_timeout <= r_timeout + 16'd1;
          end
        end
        S_DECODE: begin
          if (!w_is_legal) begin
            r_state <= S_TRAP; r_halted <= 1'b1; r_trap_cause <= 2'd1;
          end else if (w_is_system) begin
            r_state <= S_TRAP; r_halted <= 1'b1; r_trap_cause <= 2'd3;
          end else begin
            r_state        <= S_EXECUTE;
            r_alu_op       <= w_alu_op;
            r_alu_asrc     <= w_alu_asrc;
            r_alu_bsrc     <= w_alu_bsrc;
            r_imm_sel      <= w_imm_sel;
            r_cmp_unsigned <= w_cmp_unsigned;
            r_branch       <= w_branch;
            r_pc_we        <= w_is_branch || w_is_fence;
          end
        end
        S_EXECUTE: begin
          if (w_is_branch || w_is_fence) begin
            r_state <= S_FETCH; r_mem_req <= 1'b1; r_timeout <= 16'd0;
            r_alu_op <= 4'd0; r_alu_asrc <= 2'd0; r_alu_bsrc <= 1'b0;
            r_imm_sel <= 3'd0; r_cmp_unsigned <= 1'b0;
          end else if (w_is_load || w_is_store) begin
            r_state <= S_MEM; r_mem_req <= 1'b1; r_mem_addr_sel <= 1'b1;
            r_mem_we <= w_is_store; r_timeout <= 16'd0;
          end else begin
            r_state <= S_WRITEBACK; r_reg_we <= 1'b1; r_pc_we <= 1'b1;
            r_wb_sel <= w_wb_sel; r_branch <= w_branch;
          end
        end
        S_MEM: begin
          if (w_ready && r_mem_we) begin
            r_state <= S_FETCH; r_mem_req <= 1'b1; r_timeout <= 16'd0;
          end else if (w_ready) begin
            r_state <= S_WRITEBACK; r_reg_we <= 1'b1; r_pc_we <= 1'b1; r_wb_sel <= w_wb_sel;
          end else if (w_timeout_hit) begin
            r_state <= S_TRAP; r_halted <= 1'b1; r_trap_cause <= 2'd2;
          end else begin
            r_mem_req <= 1'b1; r_mem_addr_sel <= 1'b1; r_mem_we <= r_mem_we;
            r_timeout <= r_timeout + 16'd1;
          end
        end
        S_WRITEBACK: begin
          r_state <= S_FETCH; r_mem_req <= 1'b1; r_timeout <= 16'd0;
        end
        default: r_state <= S_TRAP;
      endcase
    end
  end

  assign io_mem.mem_req      = r_mem_req;
  assign io_mem.mem_we       = r_mem_we;
  assign io_mem.mem_addr_sel = r_mem_addr_sel;
  assign o_ir_we        = (r_state == S_FETCH) && w_ready;
  // A store retires the cycle memory accepts it; everything else retires from a register.
  assign o_pc_we        = r_pc_we || ((r_state == S_MEM) && r_mem_we && w_ready);
  assign o_reg_we       = r_reg_we;
  assign o_alu_op       = r_alu_op;
  assign o_alu_asrc     = r_alu_asrc;
  assign o_alu_bsrc     = r_alu_bsrc;
  assign o_imm_sel      = r_imm_sel;
  assign o_wb_sel       = r_wb_sel;
  assign o_branch       = r_branch;
  assign o_cmp_unsigned = r_cmp_unsigned;
  assign o_halted       = r_halted;
  assign o_trap_cause   = r_trap_cause;

`ifdef RV_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] r_cycle_count, r_instret_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      if (!r_halted) r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
      if (o_pc_we)   r_instret_count <= r_instret_count + CNT_WIDTH'(1);
    end
  end

  assign o_cycle_count   = r_cycle_count;
  assign o_instret_count = r_instret_count;
`endif
endmodule
